// File: rtl/bird_launch_sequencer_if.sv
// Handshake bundle between the key/frame logic and the bird launch sequencer.
// Inputs are frame-level levels or pulses; launch is a one-cycle registered pulse.
interface bird_launch_sequencer_if;
  logic       startOfFrame;
  logic       startGame;
  logic       angle_up_key;
  logic       angle_down_key;
  logic       fire_key;
  logic       bird_disappear;
  logic       collisionBird;
  logic       launch;
  logic [3:0] aim_angle;
  logic [3:0] launch_power;
  logic       bird_active;
  logic [2:0] bird_idx;
  logic [2:0] seq_state;

  modport master (
    output startOfFrame, startGame, angle_up_key, angle_down_key, fire_key,
           bird_disappear, collisionBird,
    input  launch, aim_angle, launch_power, bird_active, bird_idx, seq_state
  );

  modport slave (
    input  startOfFrame, startGame, angle_up_key, angle_down_key, fire_key,
           bird_disappear, collisionBird,
    output launch, aim_angle, launch_power, bird_active, bird_idx, seq_state
  );
endinterface

// File: rtl/bird_launch_sequencer.sv
// Per-bird shot sequencer: aim, charge, launch, flight, settle, next bird.
// Optional AUTO_FIRE_TIMEOUT_EN adds an AIM idle timeout that launches at half power.
module bird_launch_sequencer #(
  parameter int NUM_BIRDS         = 5,
  parameter int ANGLE_DEFAULT     = 4,
  parameter int ANGLE_MAX         = 15,
  parameter int POWER_MAX         = 15,
  parameter int POWER_STEP_FRAMES = 3,
  parameter int SETTLE_FRAMES     = 20
`ifdef AUTO_FIRE_TIMEOUT_EN
  , parameter int AUTO_FIRE_FRAMES = 150
`endif
) (
  input logic                    clk,
  input logic                    resetN,
  bird_launch_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AIM    = 3'd1,
    S_CHARGE = 3'd2,
    S_FLIGHT = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  localparam logic [3:0] ANGLE_DEF_C = 4'(ANGLE_DEFAULT);
  localparam logic [3:0] ANGLE_MAX_C = 4'(ANGLE_MAX);
  localparam logic [3:0] POWER_MAX_C = 4'(POWER_MAX);
  localparam logic [7:0] STEP_C      = 8'(POWER_STEP_FRAMES);
  localparam logic [7:0] SETTLE_C    = 8'(SETTLE_FRAMES);
  localparam logic [2:0] LAST_BIRD_C = 3'(NUM_BIRDS - 1);
`ifdef AUTO_FIRE_TIMEOUT_EN
  localparam logic [7:0] AUTO_C      = 8'(AUTO_FIRE_FRAMES);
  localparam logic [3:0] AUTO_PWR_C  = 4'(POWER_MAX / 2);
`endif

  state_t     state_q, state_d;
  logic [3:0] angle_q, angle_d;
  logic [3:0] power_q, power_d;
  logic [3:0] lpower_q, lpower_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;
  logic       launch_q, launch_d;
  logic       fire_hist_q;
  logic       fire_rise;

  assign fire_rise = bus.fire_key & ~fire_hist_q;
  assign cnt_inc   = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      angle_q     <= 4'd0;
      power_q     <= 4'd0;
      lpower_q    <= 4'd0;
      idx_q       <= 3'd0;
      cnt_q       <= 8'd0;
      launch_q    <= 1'b0;
      fire_hist_q <= 1'b0;
    end else begin
      angle_q     <= angle_d;
      power_q     <= power_d;
      lpower_q    <= lpower_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      launch_q    <= launch_d;
      fire_hist_q <= bus.fire_key;
    end
  end

  always_comb begin
    state_d  = state_q;
    angle_d  = angle_q;
    power_d  = power_q;
    lpower_d = lpower_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    launch_d = 1'b0;

    if (!bus.startGame) begin
      // Leaving play wins over everything, including a pending release.
      state_d  = S_IDLE;
      idx_d    = 3'd0;
      power_d  = 4'd0;
      lpower_d = 4'd0;
      cnt_d    = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_AIM;
          angle_d  = ANGLE_DEF_C;
          power_d  = 4'd0;
          lpower_d = 4'd0;
          idx_d    = 3'd0;
          cnt_d    = 8'd0;
        end
        S_AIM: begin
          if (bus.startOfFrame) begin
            if (bus.angle_up_key && !bus.angle_down_key && angle_q != ANGLE_MAX_C)
              angle_d = angle_q + 4'd1;
            else if (bus.angle_down_key && !bus.angle_up_key && angle_q != 4'd0)
              angle_d = angle_q - 4'd1;
          end
`ifdef AUTO_FIRE_TIMEOUT_EN
          if (bus.angle_up_key || bus.angle_down_key || bus.fire_key) begin
            cnt_d = 8'd0;
          end else if (bus.startOfFrame) begin
            if (cnt_inc == AUTO_C) begin
              launch_d = 1'b1;
              lpower_d = AUTO_PWR_C;
              state_d  = S_FLIGHT;
              cnt_d    = 8'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
`endif
          if (fire_rise) begin
            state_d = S_CHARGE;
            power_d = 4'd0;
            cnt_d   = 8'd0;
          end
        end
        S_CHARGE: begin
          if (!bus.fire_key) begin
            launch_d = 1'b1;
            lpower_d = (power_q == 4'd0) ? 4'd1 : power_q;
            state_d  = S_FLIGHT;
            cnt_d    = 8'd0;
          end else if (bus.startOfFrame) begin
            if (cnt_inc == STEP_C) begin
              cnt_d = 8'd0;
              if (power_q != POWER_MAX_C) power_d = power_q + 4'd1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_FLIGHT: begin
          if (bus.bird_disappear || bus.collisionBird) begin
            state_d = S_SETTLE;
            cnt_d   = 8'd0;
          end
        end
        S_SETTLE: begin
          if (bus.startOfFrame) begin
            if (cnt_inc == SETTLE_C) begin
              cnt_d = 8'd0;
              if (idx_q == LAST_BIRD_C) begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
              end else begin
                state_d  = S_AIM;
                idx_d    = idx_q + 3'd1;
                angle_d  = ANGLE_DEF_C;
                power_d  = 4'd0;
                lpower_d = 4'd0;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.launch       = launch_q;
  assign bus.aim_angle    = angle_q;
  assign bus.launch_power = lpower_q;
  assign bus.bird_active  = (state_q == S_FLIGHT);
  assign bus.bird_idx     = idx_q;
  assign bus.seq_state    = state_q;

endmodule
